idct_2d_4x4: RTL
================

# idct_2d_4x4

Inverse 4x4 2D integer transform, the decoder-side counterpart of the forward 2D DCT block. It accepts one coefficient row per cycle on four signed lanes and applies the 1D inverse butterfly to each row. Rows go into a ping-pong transpose buffer; the block then applies the column pass, rounds, and clips to 8-bit pixels. Output is one column of four pixels per cycle, so back-to-back blocks stream with no bubbles and no backpressure.

## Interface
- CW, 16: coefficient width (signed, two's complement)
- PW, 8: output pixel width (unsigned)
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- cin0..cin3  in  CW each  coefficients of current row, lane j = column j
- cin_valid  in  1  row present this cycle
- dout0..dout3  out  PW each  pixels of current output column, lane i = row i
- dout_valid  out  1  dout lanes valid
- dout_last  out  1  high with the 4th (final) column of a block

## Operation
- 1D inverse butterfly, used for both passes, on inputs d0..d3:
  - e=d0+d2, f=d0−d2, g=(d1>>>1)−d3, h=d1+(d3>>>1)
  - y0=e+h, y1=f+g, y2=f−g, y3=e−h
  - Arithmetic shifts.
- Widths: row pass is CW+2 bits (18); column pass is CW+4 bits (20). There is no internal overflow.
- Final stage per lane: p=(y+32)>>>6, then clip to [0, 255].
- Write side:
  - Row counter wr_row (0..3) and bank select wr_bank.
  - On each cin_valid, the row-transformed values are written to bank[wr_bank] row wr_row, and wr_row increments.
  - At wr_row==3 with cin_valid: wr_row wraps to 0, wr_bank toggles, and the completed bank is handed to the read side.
  - cin_valid low holds the write state. Gaps between rows are allowed.
- Read side FSM:
  - States are IDLE and DRAIN, with column counter rd_col (0..3).
  - IDLE→DRAIN on block handoff. In DRAIN, column rd_col of the full bank is column-transformed and registered onto dout.
  - rd_col==3: if a new handoff arrives in the same cycle, stay in DRAIN and restart at col 0 on the other bank; otherwise go to IDLE.
- No conflict by construction: a bank drains in exactly 4 cycles, and the next block needs at least 4 input cycles.

## Timing
- Reset values: dout0..3=0, dout_valid=0, dout_last=0, wr_row=0, wr_bank=0, rd_col=0, state=IDLE. Both banks are cleared.
- Latency: if the 4th row is sampled at edge k, columns 0..3 are registered at edges k+1..k+4. dout_valid is high for exactly those 4 cycles, and dout_last is high after edge k+4.
- Back-to-back blocks (16 consecutive cin_valid cycles or more) give continuous dout_valid with no gap.
- dout holds its last value when dout_valid=0.
- Reset mid-operation:
  - All state clears immediately (asynchronous).
  - A partial block is discarded, and any drain in progress is aborted; dout_valid drops at reset assertion.
- Release is synchronous to the clock edge. The first cin_valid after release counts as row 0.

## Structure
- Package idct_pkg holds:
  - CW, PW, row/column widths, and the rounding constant 32 with shift 6
  - function clip_pixel(signed in) returning PW bits
  - the read FSM state enum
- Sub-module idct_1d_4: combinational butterfly with parameter width W. It is instantiated twice: once for rows (W=CW) and once for columns (W=CW+2).

## Test plan
- DC only: c[0][0]=640, rest 0 → 4 valid cycles, all lanes 10, dout_last on the 4th.
- Saturation: DC=20000 → all pixels 255. DC=−640 → all pixels 0.
- Orientation: c[0][0]=6400, c[0][1]=640 → per-cycle output is all lanes 110, then 105, then 95, then 90.
- Streaming: block DC=640, then block DC=1280 with no gap → 8 contiguous valid cycles, values 10×4 then 20×4, dout_last on cycles 4 and 8.
- Gapped input: rows with 3-cycle cin_valid gaps, DC=640 → same values; the first valid output comes one cycle after the 4th row.
- Reset:
  - Assert rst after 2 rows → no output. The next full DC=640 block gives 10s normally.
  - Assert rst during drain → dout_valid drops immediately.

Source files
------------

// File: rtl/idct_pkg.sv
// idct_pkg: shared widths, rounding constants, pixel clip helper
// and read-side state encoding for the 4x4 inverse transform.
package idct_pkg;

   localparam int CW   = 16;
   localparam int PW   = 8;
   localparam int RW   = CW + 2;
   localparam int CLW  = CW + 4;
   localparam int RND  = 32;
   localparam int SH   = 6;
   localparam int PMAX = (1 << PW) - 1;

   typedef enum logic {
      IDLE,
      DRAIN
   } rd_state_e;

   // Round by 1/64 then saturate into the unsigned pixel range.
   function automatic logic [PW-1:0] clip_pixel(
      input logic signed [CLW-1:0] y
   );
      logic signed [CLW:0] t;
      logic signed [CLW:0] lim;
      lim = (CLW+1)'(PMAX);
      t   = (CLW+1)'(y) + (CLW+1)'(RND);
      t   = t >>> SH;
      if (t[CLW]) begin
         return '0;
      end
      if (t > lim) begin
         return '1;
      end
      return t[PW-1:0];
   endfunction

endpackage

// File: rtl/idct_1d_4.sv
// idct_1d_4: combinational 4-point inverse butterfly.
// Output grows by two bits over the input width.
module idct_1d_4 #(
   parameter int W = 16
) (
   input  logic signed [W-1:0] d0_i,
   input  logic signed [W-1:0] d1_i,
   input  logic signed [W-1:0] d2_i,
   input  logic signed [W-1:0] d3_i,
   output logic signed [W+1:0] y0_o,
   output logic signed [W+1:0] y1_o,
   output logic signed [W+1:0] y2_o,
   output logic signed [W+1:0] y3_o
);

   localparam int OW = W + 2;

   logic signed [OW-1:0] a0, a1, a2, a3;
   logic signed [OW-1:0] e, f, g, h;

   // Even/odd split, odd half uses halved cross terms.
   always_comb begin
      a0   = OW'(d0_i);
      a1   = OW'(d1_i);
      a2   = OW'(d2_i);
      a3   = OW'(d3_i);
      e    = a0 + a2;
      f    = a0 - a2;
      g    = (a1 >>> 1) - a3;
      h    = a1 + (a3 >>> 1);
      y0_o = e + h;
      y1_o = f + g;
      y2_o = f - g;
      y3_o = e - h;
   end

endmodule

// File: rtl/idct_2d_4x4.sv
// idct_2d_4x4: row pass into a ping-pong transpose buffer, then
// column pass, round and clip; one pixel column out per cycle.
module idct_2d_4x4
   import idct_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic signed [CW-1:0] cin0,
   input  logic signed [CW-1:0] cin1,
   input  logic signed [CW-1:0] cin2,
   input  logic signed [CW-1:0] cin3,
   input  logic                 cin_valid,
   output logic [PW-1:0]        dout0,
   output logic [PW-1:0]        dout1,
   output logic [PW-1:0]        dout2,
   output logic [PW-1:0]        dout3,
   output logic                 dout_valid,
   output logic                 dout_last
);

   logic signed [RW-1:0]  row_y [4];
   logic signed [RW-1:0]  bank_q [2][4][4];
   logic signed [RW-1:0]  col_x [4];
   logic signed [CLW-1:0] col_y [4];

   logic [1:0] wr_row_q, wr_row_d;
   logic       wr_bank_q, wr_bank_d;
   logic       handoff;

   rd_state_e  state_q, state_d;
   logic [1:0] rd_col_q, rd_col_d;
   logic       rd_bank_q, rd_bank_d;
   logic       drain_en;

   logic [PW-1:0] dout_q [4];
   logic          valid_q, last_q;

   idct_1d_4 #(.W(CW)) u_row (
      .d0_i (cin0),
      .d1_i (cin1),
      .d2_i (cin2),
      .d3_i (cin3),
      .y0_o (row_y[0]),
      .y1_o (row_y[1]),
      .y2_o (row_y[2]),
      .y3_o (row_y[3])
   );

   idct_1d_4 #(.W(RW)) u_col (
      .d0_i (col_x[0]),
      .d1_i (col_x[1]),
      .d2_i (col_x[2]),
      .d3_i (col_x[3]),
      .y0_o (col_y[0]),
      .y1_o (col_y[1]),
      .y2_o (col_y[2]),
      .y3_o (col_y[3])
   );

   // Write pointer advance; 4th row flips bank and hands it off.
   always_comb begin
      wr_row_d  = wr_row_q;
      wr_bank_d = wr_bank_q;
      handoff   = 1'b0;
      if (cin_valid) begin
         wr_row_d = wr_row_q + 2'd1;
         if (wr_row_q == 2'd3) begin
            wr_bank_d = ~wr_bank_q;
            handoff   = 1'b1;
         end
      end
   end

   // Write pointer registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_row_q  <= '0;
         wr_bank_q <= 1'b0;
      end else begin
         wr_row_q  <= wr_row_d;
         wr_bank_q <= wr_bank_d;
      end
   end

   // Transpose storage: row-transformed values land by row.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < 2; b++) begin
            for (int r = 0; r < 4; r++) begin
               for (int c = 0; c < 4; c++) begin
                  bank_q[b][r][c] <= '0;
               end
            end
         end
      end else if (cin_valid) begin
         for (int c = 0; c < 4; c++) begin
            bank_q[wr_bank_q][wr_row_q][c] <= row_y[c];
         end
      end
   end

   // Read one column of the draining bank.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         col_x[i] = bank_q[rd_bank_q][i][rd_col_q];
      end
   end

   // Drain sequencing; a handoff on the last column chains blocks.
   always_comb begin
      state_d   = state_q;
      rd_col_d  = rd_col_q;
      rd_bank_d = rd_bank_q;
      drain_en  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (handoff) begin
               state_d   = DRAIN;
               rd_col_d  = '0;
               rd_bank_d = wr_bank_q;
            end
         end
         DRAIN: begin
            drain_en = 1'b1;
            if (rd_col_q == 2'd3) begin
               rd_col_d = '0;
               if (handoff) begin
                  rd_bank_d = wr_bank_q;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               rd_col_d = rd_col_q + 2'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Read-side state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         rd_col_q  <= '0;
         rd_bank_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rd_col_q  <= rd_col_d;
         rd_bank_q <= rd_bank_d;
      end
   end

   // Output column register; pixels hold while not draining.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            dout_q[i] <= '0;
         end
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         valid_q <= drain_en;
         last_q  <= drain_en && (rd_col_q == 2'd3);
         if (drain_en) begin
            for (int i = 0; i < 4; i++) begin
               dout_q[i] <= clip_pixel(col_y[i]);
            end
         end
      end
   end

   assign dout0      = dout_q[0];
   assign dout1      = dout_q[1];
   assign dout2      = dout_q[2];
   assign dout3      = dout_q[3];
   assign dout_valid = valid_q;
   assign dout_last  = last_q;

endmodule
